// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one word read outstanding and
// buffers returned words in a small FIFO whose head drives decode directly.
module fetch_unit #(
  parameter logic [31:0] PC_RESET  = 32'h8002_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        insn_valid,
  output logic [31:0] insn_out,
  output logic [31:0] pc_out
);
  localparam int PW = (BUF_DEPTH > 2) ? 2 : 1;
  localparam int CW = 3;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN} state_t;

  state_t        r_state;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_drain_addr;
  logic [31:0]   r_insn [BUF_DEPTH];
  logic [31:0]   r_pc   [BUF_DEPTH];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [CW-1:0] r_count;

  logic          w_pop;
  logic          w_push;
  logic          w_issue;
  logic [CW-1:0] w_count_next;
  logic [31:0]   w_redir_pc;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_redir_pc   = redirect_pc & ~32'h3;
  assign w_pop        = (r_count != '0) && !stall && !redirect;
  assign w_push       = (r_state == S_REQ) && mem_ack && !redirect;
  assign w_count_next = redirect ? '0 : r_count + CW'(w_push) - CW'(w_pop);
  // Only launch when a slot is guaranteed for the returning word, so
  // mem_rdata never needs backpressure.
  assign w_issue      = ({1'b0, w_count_next} + 4'd1) <= 4'(BUF_DEPTH);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
      if (redirect) begin
        r_rd <= '0;
        r_wr <= '0;
      end else begin
        if (w_pop)  r_rd <= f_inc(r_rd);
        if (w_push) r_wr <= f_inc(r_wr);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_insn[r_wr] <= mem_rdata;
      r_pc[r_wr]   <= r_fetch_pc;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_fetch_pc   <= PC_RESET;
      r_drain_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (redirect) begin
            r_fetch_pc <= w_redir_pc;
            r_state    <= S_REQ;
          end else if (w_issue) begin
            r_state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            if (redirect) begin
              r_fetch_pc <= w_redir_pc;
            end else begin
              r_fetch_pc <= r_fetch_pc + 32'd4;
              r_state    <= w_issue ? S_REQ : S_IDLE;
            end
          end else if (redirect) begin
            // Request already on the bus: keep presenting it until acked.
            r_drain_addr <= r_fetch_pc;
            r_fetch_pc   <= w_redir_pc;
            r_state      <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (redirect) r_fetch_pc <= w_redir_pc;
          if (mem_ack)  r_state    <= S_REQ;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_req    = (r_state != S_IDLE);
  assign mem_addr   = (r_state == S_DRAIN) ? r_drain_addr : r_fetch_pc;
  assign insn_valid = (r_count != '0);
  assign insn_out   = insn_valid ? r_insn[r_rd] : 32'h0;
  assign pc_out     = insn_valid ? r_pc[r_rd]   : 32'h0;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory model returns the address as data; expected
// PC stream is queued by stimulus and consumed by a head-of-FIFO monitor.
module tb_fetch_unit;
  localparam logic [31:0] PC_RST = 32'h8002_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        insn_valid;
  logic [31:0] insn_out;
  logic [31:0] pc_out;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_pops   = 0;
  int          mem_lat  = 0;
  int          w_cnt;
  logic [31:0] exp_q[$];
  logic [31:0] e;
  logic [31:0] frozen;

  fetch_unit #(.PC_RESET(PC_RST), .BUF_DEPTH(2)) dut (
    .clock(clock), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .insn_valid(insn_valid),
    .insn_out(insn_out), .pc_out(pc_out)
  );

  always #5 clock = ~clock;

  // Memory: ack after mem_lat wait cycles (0 = same cycle as req).
  assign mem_ack   = mem_req && (w_cnt >= mem_lat);
  assign mem_rdata = mem_addr;
  always @(posedge clock or posedge reset) begin
    if (reset)                 w_cnt <= 0;
    else if (mem_req && mem_ack) w_cnt <= 0;
    else if (mem_req)          w_cnt <= w_cnt + 1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic expect_seq(input logic [31:0] start);
    exp_q.delete();
    for (int k = 0; k < 64; k++) exp_q.push_back(start + 32'(4 * k));
  endtask

  // Monitor: every consumed head must match the next expected PC.
  always @(negedge clock) begin
    if (!reset) begin
      if (insn_valid) begin
        if (!stall && !redirect) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL pop_empty: got pc %h expected none", pc_out);
          end else begin
            e = exp_q.pop_front();
            check("head_pc", pc_out, e);
            check("head_insn", insn_out, e);
            n_pops++;
          end
        end
      end else begin
        check("nop_insn", insn_out, 32'h0);
        check("nop_pc", pc_out, 32'h0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_valid", 32'(insn_valid), 32'd0);
    check("rst_insn", insn_out, 32'h0);
    check("rst_pc", pc_out, 32'h0);

    // 1: zero-wait streaming from PC_RESET
    expect_seq(PC_RST);
    reset = 1'b0;
    @(negedge clock);
    check("t1_req_pre", 32'(mem_req), 32'd0);
    @(negedge clock);
    check("t1_req", 32'(mem_req), 32'd1);
    check("t1_addr0", mem_addr, PC_RST);
    @(negedge clock);
    check("t1_addr1", mem_addr, PC_RST + 32'd4);
    check("t1_valid", 32'(insn_valid), 32'd1);
    check("t1_pc0", pc_out, PC_RST);
    @(negedge clock);
    check("t1_addr2", mem_addr, PC_RST + 32'd8);
    check("t1_pc1", pc_out, PC_RST + 32'd4);
    repeat (4) @(negedge clock);

    // 2: stall 6 cycles, FIFO fills, request drops, head frozen
    @(posedge clock); #1 stall = 1'b1;
    @(negedge clock);
    frozen = pc_out;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("t2_frozen", pc_out, frozen);
    end
    check("t2_req_off", 32'(mem_req), 32'd0);
    check("t2_valid", 32'(insn_valid), 32'd1);
    @(posedge clock); #1 stall = 1'b0;
    repeat (5) @(negedge clock);

    // 3: slow ack, redirect during wait; old address drained
    @(posedge clock); #1 mem_lat = 3;
    @(negedge clock);
    frozen = mem_addr;
    check("t3_noack", 32'(mem_ack), 32'd0);
    @(posedge clock); #1 redirect = 1'b1; redirect_pc = 32'h0000_1000;
    expect_seq(32'h0000_1000);
    @(posedge clock); #1 redirect = 1'b0;
    @(negedge clock);
    check("t3_hold_addr", mem_addr, frozen);
    check("t3_hold_req", 32'(mem_req), 32'd1);
    @(negedge clock);
    check("t3_drain_addr", mem_addr, frozen);
    check("t3_drain_ack", 32'(mem_ack), 32'd1);
    @(posedge clock); #1 mem_lat = 0;
    @(negedge clock);
    check("t3_new_addr", mem_addr, 32'h0000_1000);
    check("t3_nvalid", 32'(insn_valid), 32'd0);
    @(negedge clock);
    check("t3_first_pc", pc_out, 32'h0000_1000);
    repeat (3) @(negedge clock);

    // 4: redirect with FIFO full and stall held
    @(posedge clock); #1 stall = 1'b1;
    repeat (3) @(negedge clock);
    check("t4_full_req", 32'(mem_req), 32'd0);
    check("t4_full_valid", 32'(insn_valid), 32'd1);
    @(posedge clock); #1 redirect = 1'b1; redirect_pc = 32'h0000_2000;
    expect_seq(32'h0000_2000);
    @(posedge clock); #1 redirect = 1'b0; stall = 1'b0;
    @(negedge clock);
    check("t4_flushed", 32'(insn_valid), 32'd0);
    check("t4_addr", mem_addr, 32'h0000_2000);
    @(negedge clock);
    check("t4_first_pc", pc_out, 32'h0000_2000);
    repeat (3) @(negedge clock);

    // 5: unaligned redirect target near the top of the address space
    @(posedge clock); #1 redirect = 1'b1; redirect_pc = 32'hFFFF_FFFA;
    expect_seq(32'hFFFF_FFF8);
    @(posedge clock); #1 redirect = 1'b0;
    @(negedge clock);
    check("t5_addr0", mem_addr, 32'hFFFF_FFF8);
    @(negedge clock);
    check("t5_addr1", mem_addr, 32'hFFFF_FFFC);
    @(negedge clock);
    check("t5_addr2", mem_addr, 32'h0000_0000);
    repeat (4) @(negedge clock);

    // 6: async reset mid-cycle with a full FIFO
    @(posedge clock); #1 stall = 1'b1;
    repeat (3) @(negedge clock);
    check("t6_full_valid", 32'(insn_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("t6_async_valid", 32'(insn_valid), 32'd0);
    check("t6_async_insn", insn_out, 32'h0);
    check("t6_async_pc", pc_out, 32'h0);
    check("t6_async_req", 32'(mem_req), 32'd0);
    expect_seq(PC_RST);
    stall = 1'b0;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("t6_refetch_req", 32'(mem_req), 32'd1);
    check("t6_refetch_addr", mem_addr, PC_RST);
    repeat (6) @(negedge clock);

    check("pops_seen", 32'(n_pops >= 20), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
